// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult
// Multi-cycle shift-add multiplier. Each operation multiplies two WIDTH-bit
// operands and produces a 2*WIDTH-bit result. One shift-add step runs per
// clock. Operands can be unsigned or signed two's complement, chosen per
// operation. Signed operations multiply the operand magnitudes and then fix
// the sign at the end. This is the multiply unit used next to the ALU for the
// multi-cycle MULT/MULTU instructions.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        starts a new multiply; accepted only while idle
//   is_signed    1 = signed operands, 0 = unsigned; sampled with start
//   multiplicand operand A, sampled with start
//   multiplier   operand B, sampled with start
//   busy         high while an operation is in progress
//   done         one-cycle pulse when product is updated
//   product      result register; holds its value until the next done
// ---------------------------------------------------------------------------
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   is_signed,
  input  logic [WIDTH-1:0]       multiplicand,
  input  logic [WIDTH-1:0]       multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  mcand;
  logic [CW-1:0]     count;
  logic              neg;

  logic              last_step;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;

  // Two's-complement magnitude. The most negative value maps to
  // 2^(WIDTH-1). That still fits because the result is read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    if (sgn && v[WIDTH-1])
      return (~v) + one;
    else
      return v;
  endfunction

  assign a_mag     = magnitude(multiplicand, is_signed);
  assign b_mag     = magnitude(multiplier, is_signed);
  assign last_step = (count == CW'(WIDTH - 1));
  assign acc       = {hi, lo};

  // The sum is one bit wider than hi so the add carry is kept. On the right
  // shift, that carry becomes the new MSB of hi.
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step)
          state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load the magnitudes when an operation starts, run one
  // shift-add step per RUN cycle, and apply the sign once in FIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      count   <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_mag;
            lo    <= b_mag;
            hi    <= '0;
            count <= '0;
            neg   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          end
        end
        RUN: begin
          hi    <= sum[WIDTH:1];
          lo    <= {sum[0], lo[WIDTH-1:1]};
          count <= count + CW'(1);
        end
        FIX: begin
          // Negating a zero result gives zero again, so the product is
          // never a "negative zero".
          product <= neg ? -acc : acc;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_mult
// Self-checking bench for seq_mult. It drives a 32-bit and an 8-bit instance
// from a table of directed vectors with hand-computed products. Handwritten
// sequences then cover the multi-cycle cases: start while busy, a
// back-to-back start in the done cycle, and a reset in the middle of an
// operation.
// ---------------------------------------------------------------------------
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start32, signed32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] prod32;

  logic        start8, signed8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;

  int assertions = 0;
  int failures   = 0;
  int dc32       = 0;

  seq_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(signed32),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32), .done(done32), .product(prod32)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(signed8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  always #5 clk = ~clk;

  // Count every cycle in which done is high on the 32-bit unit. This shows
  // the number of done pulses over a window.
  always @(negedge clk) begin
    if (done32) dc32 <= dc32 + 1;
  end

  typedef struct {
    logic        use8;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive start and the operands before a rising edge, then scramble the
  // operands after the edge. Inputs may change once start has been sampled.
  task automatic applyStimulus(input logic use8, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (use8) begin
      start8 = 1'b1; signed8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; signed32 = sgn; a32 = a; b32 = b;
    end
    @(posedge clk);
    #1;
    if (use8) begin
      start8 = 1'b0; signed8 = ~sgn; a8 = 8'($urandom); b8 = 8'($urandom);
    end else begin
      start32 = 1'b0; signed32 = ~sgn; a32 = $urandom; b32 = $urandom;
    end
  endtask

  // Count rising edges, including the start edge, until done is seen. The
  // task returns at the falling edge where done is high.
  task automatic waitDone(input logic use8, output int edges, output logic ok);
    edges = 1;
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (use8 ? done8 : done32) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int    edges;
    logic  ok;
    logic  hold;
    int    base;

    vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000006, 64'hFFFFFFFFFFFFFFD6});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFF9, 32'h00000006, 64'h00000005FFFFFFD6});
    vecs.push_back('{1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001});
    vecs.push_back('{1'b0, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF80000001});
    vecs.push_back('{1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFB, 64'h0000000000000000});
    vecs.push_back('{1'b0, 1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000});
    vecs.push_back('{1'b1, 1'b1, 32'h00000080, 32'h00000080, 64'h0000000000004000});
    vecs.push_back('{1'b1, 1'b1, 32'h00000080, 32'h0000007F, 64'h000000000000C080});
    vecs.push_back('{1'b1, 1'b1, 32'h00000000, 32'h00000085, 64'h0000000000000000});
    vecs.push_back('{1'b1, 1'b0, 32'h000000FF, 32'h000000FF, 64'h000000000000FE01});
    vecs.push_back('{1'b1, 1'b1, 32'h000000FF, 32'h00000002, 64'h000000000000FFFE});
    vecs.push_back('{1'b1, 1'b0, 32'h00000080, 32'h00000080, 64'h0000000000004000});

    rst_n   = 1'b0;
    start32 = 1'b0; signed32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; signed8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy32", busy32, 0);
    checkOutput("reset done32", done32, 0);
    checkOutput("reset prod32", prod32, 0);
    checkOutput("reset busy8",  busy8,  0);
    checkOutput("reset prod8",  prod8,  0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].use8, vecs[i].sgn, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d busy", i), vecs[i].use8 ? busy8 : busy32, 1);
      waitDone(vecs[i].use8, edges, ok);
      checkOutput($sformatf("vec%0d done seen", i), ok, 1);
      checkOutput($sformatf("vec%0d latency", i), edges, vecs[i].use8 ? 10 : 34);
      checkOutput($sformatf("vec%0d product", i),
                  vecs[i].use8 ? {48'd0, prod8} : prod32, vecs[i].exp);
      @(negedge clk);
      checkOutput($sformatf("vec%0d single done", i), vecs[i].use8 ? done8 : done32, 0);
      checkOutput($sformatf("vec%0d idle", i), vecs[i].use8 ? busy8 : busy32, 0);
    end

    // Pulse start with 9*9 while 3*5 is running. The 9*9 request is dropped.
    base = dc32;
    applyStimulus(1'b0, 1'b0, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start32 = 1'b1; a32 = 32'd9; b32 = 32'd9; signed32 = 1'b0;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    checkOutput("ignore busy", busy32, 1);
    waitDone(1'b0, edges, ok);
    checkOutput("ignore done seen", ok, 1);
    checkOutput("ignore product", prod32, 64'd15);
    repeat (50) @(negedge clk);
    checkOutput("ignore done count", dc32 - base, 1);

    // Start 2*3 in the done cycle of 4*4. The old result holds until the
    // new FIX step.
    applyStimulus(1'b0, 1'b0, 32'd4, 32'd4);
    waitDone(1'b0, edges, ok);
    checkOutput("b2b first done", ok, 1);
    checkOutput("b2b first product", prod32, 64'd16);
    start32 = 1'b1; a32 = 32'd2; b32 = 32'd3; signed32 = 1'b0;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    hold = 1'b1;
    repeat (33) begin
      @(negedge clk);
      if (prod32 !== 64'd16 || done32 !== 1'b0) hold = 1'b0;
    end
    checkOutput("b2b hold previous", hold, 1);
    @(negedge clk);
    checkOutput("b2b second done", done32, 1);
    checkOutput("b2b second product", prod32, 64'd6);

    // Assert reset in the middle of a 32-bit operation.
    applyStimulus(1'b0, 1'b0, 32'h0000FFFF, 32'h0000FFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    base  = dc32;
    @(posedge clk);
    #1;
    checkOutput("midreset busy", busy32, 0);
    checkOutput("midreset done", done32, 0);
    checkOutput("midreset product", prod32, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("midreset no done", dc32 - base, 0);
    applyStimulus(1'b0, 1'b1, 32'd7, 32'hFFFFFFF8);
    waitDone(1'b0, edges, ok);
    checkOutput("postreset done seen", ok, 1);
    checkOutput("postreset latency", edges, 34);
    checkOutput("postreset product", prod32, 64'hFFFFFFFFFFFFFFC8);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised multi-cycle shift-add multiplier: WIDTH x WIDTH operands give a 2*WIDTH product.
- Supports unsigned and signed (two's complement) operands, selected per operation.
- Iterates the product/multiplier shift-add step once per clock under an internal FSM, with a start/busy/done handshake.
- Sits beside the ALU as the multiply unit for multi-cycle MULT/MULTU operations.

Parameters:
WIDTH, 32, operand width in bits; legal range 4..64; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
start  input  1  request a new multiply; honoured only in IDLE.
is_signed  input  1  1 = signed two's-complement operands, 0 = unsigned; sampled with start.
multiplicand  input  WIDTH  operand A; sampled with start.
multiplier  input  WIDTH  operand B; sampled with start.
busy  output  1  high while an operation is in progress (RUN or FIX).
done  output  1  one-cycle pulse when product becomes valid.
product  output  2*WIDTH  result register; holds last result until the next done.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0; done=0; product=0; all internal registers (hi, lo, mcand, count, neg) cleared. Reset overrides any state, including mid-operation; the aborted result is discarded and no done is produced.
- FSM states are IDLE, RUN and FIX.
- IDLE, start=1 at edge N:
  - mcand <= |multiplicand| when is_signed=1, else multiplicand.
  - lo <= |multiplier| (same rule); hi <= 0; count <= 0.
  - neg <= is_signed & (multiplicand[W-1] ^ multiplier[W-1]).
  - Go to RUN; busy=1 from edge N.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held as an unsigned WIDTH-bit value (no overflow).
- RUN, one step per edge, exactly WIDTH steps (edges N+1..N+WIDTH):
  - sum = {1'b0,hi} + (lo[0] ? mcand : 0), computed WIDTH+1 bits wide.
  - {hi,lo} <= {sum,lo} >> 1; the carry enters hi's MSB and hi's LSB enters lo's MSB.
  - count <= count+1; after step WIDTH (count==WIDTH-1 at the edge) go to FIX.
- FIX, edge N+WIDTH+1:
  - product <= neg ? -{hi,lo} : {hi,lo}, negated modulo 2^(2*WIDTH).
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: start sampled at edge N gives done=1 and a valid product in the cycle after edge N+WIDTH+1. Throughput is one result per WIDTH+2 cycles.
- start while busy=1 is ignored; operands are not re-sampled.
- start=1 in the same cycle done=1 (state is IDLE) is accepted; the new operation begins, done drops next cycle, and product holds the previous result until the new FIX.
- Operand inputs may change freely after the start edge.
- Zero operand: runs the full WIDTH steps and gives product=0, never negative zero (negation of 0 is 0).
- Signed range: (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2), which fits as a positive value.
- Unsigned max: (2^W-1)^2 is exact in 2*WIDTH bits.

Test Plan:
- WIDTH=32, unsigned, 0xFFFFFFFF * 0xFFFFFFFF -> done exactly 34 cycles after the start edge; product=0xFFFFFFFE00000001.
- WIDTH=32, signed, -7 (0xFFFFFFF9) * 6 -> product=0xFFFFFFFFFFFFFFD6 (-42). Same operands with is_signed=0 -> 0x00000005FFFFFFD6.
- WIDTH=8, signed, 0x80*0x80 -> 0x4000. Signed 0x80*0x7F -> 0xC080. Signed 0*0x85 -> 0x0000. Each has done 10 cycles after start.
- WIDTH=32, start 3*5; pulse start with 9*9 at cycle 5 (busy) -> ignored; product=15, single done pulse.
- Back-to-back: assert start with 2*3 in the done cycle of a previous 4*4 -> product=16 for 34 cycles, then 6.
- rst_n=0 at cycle 10 of a 32-bit multiply -> next cycle busy=0, done=0, product=0; no done follows. New start after reset completes correctly.
